// File: rtl/dma_xfer_sched_if.sv
// dma_xfer_sched_if: requester and DMA handshake bundle for the
// DMA transfer scheduler.
interface dma_xfer_sched_if #(
    parameter int LEN_W = 8
) ();
    logic             c2m_req;
    logic [LEN_W-1:0] c2m_len;
    logic             m2c_req;
    logic [LEN_W-1:0] m2c_len;
    logic             dma_to_mem_valid;
    logic             dma_to_mem_enable;
    logic             dma_to_cpu_valid;
    logic             dma_to_cpu_enable;
    logic             c2m_grant;
    logic             m2c_grant;
    logic             mode;
    logic             dma_run;
    logic             busy;
    logic             done;
    logic             done_dir;
    logic [LEN_W-1:0] xfer_cnt;

    // scheduler side
    modport slave (
        input  c2m_req, c2m_len, m2c_req, m2c_len,
        input  dma_to_mem_valid, dma_to_mem_enable,
        input  dma_to_cpu_valid, dma_to_cpu_enable,
        output c2m_grant, m2c_grant, mode, dma_run,
        output busy, done, done_dir, xfer_cnt
    );

    // requester / DMA side
    modport master (
        output c2m_req, c2m_len, m2c_req, m2c_len,
        output dma_to_mem_valid, dma_to_mem_enable,
        output dma_to_cpu_valid, dma_to_cpu_enable,
        input  c2m_grant, m2c_grant, mode, dma_run,
        input  busy, done, done_dir, xfer_cnt
    );
endinterface

// File: rtl/dma_xfer_sched.sv
// dma_xfer_sched: round-robin CPU<->MEM transfer scheduler that gates
// the DMA engine and counts completed bytes from its handshakes.
module dma_xfer_sched #(
    parameter int LEN_W = 8
) (
    input logic               clk,
    input logic               resetn,
    dma_xfer_sched_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]       state;
    logic             last_dir;
    logic             half;
    logic [LEN_W-1:0] len_q;

    logic             any_req;
    logic             pick_c2m;
    logic             fire;
    logic [LEN_W-1:0] cnt_next;

    // arbitration and handshake decode; fires only count while dma_run is up
    always_comb begin
        any_req  = bus.c2m_req | bus.m2c_req;
        pick_c2m = bus.c2m_req & (~bus.m2c_req | ~last_dir);
        if (bus.mode)
            fire = bus.dma_run & bus.dma_to_mem_valid & bus.dma_to_mem_enable;
        else
            fire = bus.dma_run & bus.dma_to_cpu_valid & bus.dma_to_cpu_enable;
        cnt_next = bus.xfer_cnt + 1'b1;
    end

    // scheduler FSM, byte counter and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            last_dir      <= 1'b0;
            half          <= 1'b0;
            len_q         <= '0;
            bus.c2m_grant <= 1'b0;
            bus.m2c_grant <= 1'b0;
            bus.mode      <= 1'b0;
            bus.dma_run   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.done_dir  <= 1'b0;
            bus.xfer_cnt  <= '0;
        end else begin
            bus.c2m_grant <= 1'b0;
            bus.m2c_grant <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state         <= S_SETUP;
                        bus.c2m_grant <= pick_c2m;
                        bus.m2c_grant <= ~pick_c2m;
                        bus.mode      <= pick_c2m;
                        len_q         <= pick_c2m ? bus.c2m_len
                                                  : bus.m2c_len;
                        bus.xfer_cnt  <= '0;
                        half          <= 1'b0;
                        bus.busy      <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (len_q == '0) begin
                        state        <= S_IDLE;
                        bus.done     <= 1'b1;
                        bus.done_dir <= bus.mode;
                        bus.busy     <= 1'b0;
                        last_dir     <= bus.mode;
                    end else begin
                        state       <= S_RUN;
                        bus.dma_run <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        if (bus.mode && !half) begin
                            half <= 1'b1;
                        end else begin
                            half         <= 1'b0;
                            bus.xfer_cnt <= cnt_next;
                            if (cnt_next == len_q) begin
                                state        <= S_IDLE;
                                bus.dma_run  <= 1'b0;
                                bus.done     <= 1'b1;
                                bus.done_dir <= bus.mode;
                                bus.busy     <= 1'b0;
                                last_dir     <= bus.mode;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
